// File: rtl/ad7864_read_sequencer.sv
// Read sequencer for the AD7864 ADC: CONVST pulse, BUSY tracking, CS/RD channel
// reads, and a valid/ready sample stream to the downstream serialiser.
module ad7864_read_sequencer #(
  parameter int unsigned CONV_PULSE   = 4,
  parameter int unsigned RD_LOW       = 3,
  parameter int unsigned RD_GAP       = 2,
  parameter int unsigned BUSY_TIMEOUT = 200
) (
  input  logic        clkin,
  input  logic        rst_bar,
  input  logic        dsp_conv_bar,
  input  logic [3:0]  ch_mask,
  output logic        ad_conv_bar,
  input  logic        ad_busy,
  output logic        ad_cs_bar,
  output logic        ad_rd_bar,
  input  logic [11:0] ad_db,
  output logic [11:0] ch_data,
  output logic [1:0]  ch_idx,
  output logic        ch_valid,
  input  logic        ch_ready,
  output logic        frame_done,
  output logic        conv_overrun,
  output logic        busy_err,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONV    = 3'd1,
    WAIT_HI = 3'd2,
    WAIT_LO = 3'd3,
    RD      = 3'd4,
    HOLD    = 3'd5,
    GAP     = 3'd6,
    DONE    = 3'd7
  } state_t;

  localparam logic [7:0] CONV_LAST = 8'(CONV_PULSE);
  localparam logic [7:0] RD_LAST   = 8'(RD_LOW - 1);
  localparam logic [7:0] GAP_LAST  = 8'(RD_GAP - 1);
  localparam logic [7:0] TO_LAST   = 8'(BUSY_TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [3:0]  mask_q, mask_d;
  logic [2:0]  dsp_sync_q, dsp_sync_d;
  logic [1:0]  busy_sync_q, busy_sync_d;
  logic        ad_conv_q, ad_conv_d;
  logic        ad_cs_q, ad_cs_d;
  logic        ad_rd_q, ad_rd_d;
  logic [11:0] ch_data_q, ch_data_d;
  logic [1:0]  ch_idx_q, ch_idx_d;
  logic        ch_valid_q, ch_valid_d;
  logic        frame_done_q, frame_done_d;
  logic        conv_overrun_q, conv_overrun_d;
  logic        busy_err_q, busy_err_d;
  logic        conv_req;
  logic        busy_s;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (m[i]) r = 2'(i);
    end
    return r;
  endfunction

  // Stage 1 is the metastability flop, stage 2 the synchronised level, stage 3
  // its one-cycle-old copy; a request is stage 2 low while stage 3 is still high.
  assign conv_req = dsp_sync_q[2] & ~dsp_sync_q[1];
  assign busy_s   = busy_sync_q[1];

  // Sample handshake: ch_valid rises with ch_data/ch_idx and holds them stable
  // until a clock edge sees ch_valid & ch_ready; that edge transfers the sample.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    mask_d         = mask_q;
    dsp_sync_d     = {dsp_sync_q[1:0], dsp_conv_bar};
    busy_sync_d    = {busy_sync_q[0], ad_busy};
    ad_conv_d      = ad_conv_q;
    ad_cs_d        = ad_cs_q;
    ad_rd_d        = ad_rd_q;
    ch_data_d      = ch_data_q;
    ch_idx_d       = ch_idx_q;
    ch_valid_d     = ch_valid_q;
    frame_done_d   = 1'b0;
    conv_overrun_d = conv_req && (state_q != IDLE);
    busy_err_d     = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (conv_req && (ch_mask != 4'd0)) begin
          mask_d  = ch_mask;
          cnt_d   = 8'd0;
          state_d = CONV;
        end
      end
      CONV: begin
        // The first CONV cycle only arms the strobe, so CONVST trails the
        // request detection by one edge and stays low CONV_PULSE cycles.
        if (cnt_q == CONV_LAST) begin
          ad_conv_d = 1'b1;
          cnt_d     = 8'd0;
          state_d   = WAIT_HI;
        end else begin
          ad_conv_d = 1'b0;
          cnt_d     = cnt_q + 8'd1;
        end
      end
      WAIT_HI: begin
        if (busy_s) begin
          cnt_d   = 8'd0;
          state_d = WAIT_LO;
        end else if (cnt_q == TO_LAST) begin
          busy_err_d = 1'b1;
          ad_cs_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      WAIT_LO: begin
        if (!busy_s) begin
          ad_cs_d  = 1'b0;
          ad_rd_d  = 1'b0;
          ch_idx_d = lowest_set(mask_q);
          cnt_d    = 8'd0;
          state_d  = RD;
        end else if (cnt_q == TO_LAST) begin
          busy_err_d = 1'b1;
          ad_cs_d    = 1'b1;
          state_d    = IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      RD: begin
        if (cnt_q == RD_LAST) begin
          ch_data_d  = ad_db;
          ad_rd_d    = 1'b1;
          ch_valid_d = 1'b1;
          state_d    = HOLD;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      HOLD: begin
        if (ch_valid_q && ch_ready) begin
          ch_valid_d = 1'b0;
          mask_d     = mask_q & ~(4'b0001 << ch_idx_q);
          cnt_d      = 8'd0;
          state_d    = GAP;
        end
      end
      GAP: begin
        if (cnt_q == GAP_LAST) begin
          cnt_d = 8'd0;
          if (mask_q != 4'd0) begin
            ch_idx_d = lowest_set(mask_q);
            ad_rd_d  = 1'b0;
            state_d  = RD;
          end else begin
            state_d = DONE;
          end
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DONE: begin
        ad_cs_d      = 1'b1;
        frame_done_d = 1'b1;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clkin or negedge rst_bar) begin
    if (!rst_bar) begin
      state_q        <= IDLE;
      cnt_q          <= 8'd0;
      mask_q         <= 4'd0;
      dsp_sync_q     <= 3'b111;
      busy_sync_q    <= 2'b00;
      ad_conv_q      <= 1'b1;
      ad_cs_q        <= 1'b1;
      ad_rd_q        <= 1'b1;
      ch_data_q      <= 12'd0;
      ch_idx_q       <= 2'd0;
      ch_valid_q     <= 1'b0;
      frame_done_q   <= 1'b0;
      conv_overrun_q <= 1'b0;
      busy_err_q     <= 1'b0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      mask_q         <= mask_d;
      dsp_sync_q     <= dsp_sync_d;
      busy_sync_q    <= busy_sync_d;
      ad_conv_q      <= ad_conv_d;
      ad_cs_q        <= ad_cs_d;
      ad_rd_q        <= ad_rd_d;
      ch_data_q      <= ch_data_d;
      ch_idx_q       <= ch_idx_d;
      ch_valid_q     <= ch_valid_d;
      frame_done_q   <= frame_done_d;
      conv_overrun_q <= conv_overrun_d;
      busy_err_q     <= busy_err_d;
    end
  end

  assign ad_conv_bar  = ad_conv_q;
  assign ad_cs_bar    = ad_cs_q;
  assign ad_rd_bar    = ad_rd_q;
  assign ch_data      = ch_data_q;
  assign ch_idx       = ch_idx_q;
  assign ch_valid     = ch_valid_q;
  assign frame_done   = frame_done_q;
  assign conv_overrun = conv_overrun_q;
  assign busy_err     = busy_err_q;
  assign dbg_state    = state_q;

endmodule
